// File: rtl/periph_pkg.sv
`default_nettype none
// ============================================================================
// Module      : periph_pkg
// Description : Shared types and constants for the keypad peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package periph_pkg;

    localparam int KEY_W    = 4;
    localparam int PEND_BIT = 31;
    localparam int OVR_BIT  = 30;
    localparam int HELD_BIT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } db_state_e;

    // Returns {hit, column} for the lowest-numbered active-low column.
    function automatic logic [2:0] first_low(input logic [3:0] col);
        logic [2:0] res;
        res = 3'b000;
        for (int c = 3; c >= 0; c--) begin
            if (!col[c]) begin
                res = {1'b1, 2'(c)};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : keypad_debounce
// Description : Whole-scan press/release debouncer for the keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce
    import periph_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_done_i,
    input  logic             scan_valid_i,
    input  logic [KEY_W-1:0] scan_code_i,
    output logic             accept_o,
    output logic [KEY_W-1:0] accept_code_o,
    output logic             held_o
);

    localparam logic [3:0] c_DB_MAX = 4'(DEBOUNCE_SCANS);

    db_state_e        state_q, state_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       rel_q, rel_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        rel_d         = rel_q;
        accept_o      = 1'b0;
        accept_code_o = scan_code_i;

        if (scan_done_i) begin
            case (state_q)
                IDLE: begin
                    if (scan_valid_i) begin
                        cand_d = scan_code_i;
                        cnt_d  = 4'd1;
                        if (c_DB_MAX == 4'd1) begin
                            accept_o = 1'b1;
                            state_d  = HELD;
                            rel_d    = '0;
                            cnt_d    = '0;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!scan_valid_i) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (scan_code_i != cand_q) begin
                        cand_d = scan_code_i;
                        cnt_d  = 4'd1;
                    end else if (cnt_q + 4'd1 == c_DB_MAX) begin
                        accept_o = 1'b1;
                        state_d  = HELD;
                        rel_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                HELD: begin
                    // Any key at all, even a different one, keeps the hold alive.
                    if (scan_valid_i) begin
                        rel_d = '0;
                    end else if (rel_q + 4'd1 == c_DB_MAX) begin
                        state_d = IDLE;
                        rel_d   = '0;
                    end else begin
                        rel_d = rel_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign held_o = (state_q == HELD);

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 matrix keypad scanner with debounce and CPU status word.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan
    import periph_pkg::*;
#(
    parameter int SCAN_DIV       = 32768,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        rd,
    input  logic [3:0]  i_col,
    output logic [3:0]  o_row,
    output logic [31:0] o_data,
    output logic        o_key_irq
);

    localparam int              PW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   c_PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       row_q, row_d;
    logic [3:0]       col_meta_q, col_sync_q;
    logic             acc_valid_q, acc_valid_d;
    logic [KEY_W-1:0] acc_code_q, acc_code_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic [31:0]      data_q, data_d;

    logic             w_tick;
    logic [2:0]       w_row_hit;
    logic             w_acc_prior;
    logic             w_scan_done;
    logic             w_scan_valid;
    logic [KEY_W-1:0] w_scan_code;
    logic             w_read;
    logic             w_accept;
    logic [KEY_W-1:0] w_accept_code;
    logic             w_held;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            row_idx_q   <= 2'd0;
            row_q       <= 4'b1110;
            col_meta_q  <= 4'hF;
            col_sync_q  <= 4'hF;
            acc_valid_q <= 1'b0;
            acc_code_q  <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            code_q      <= '0;
            data_q      <= '0;
        end else begin
            presc_q     <= presc_d;
            row_idx_q   <= row_idx_d;
            row_q       <= row_d;
            col_meta_q  <= i_col;
            col_sync_q  <= col_meta_q;
            acc_valid_q <= acc_valid_d;
            acc_code_q  <= acc_code_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            code_q      <= code_d;
            data_q      <= data_d;
        end
    end

    assign w_tick    = (presc_q == c_PRESC_MAX);
    assign w_row_hit = first_low(col_sync_q);

    // Row 0 starts a fresh scan; earlier rows win because their codes are lower.
    assign w_acc_prior  = (row_idx_q != 2'd0) && acc_valid_q;
    assign w_scan_done  = w_tick && (row_idx_q == 2'd3);
    assign w_scan_valid = w_acc_prior || w_row_hit[2];
    assign w_scan_code  = w_acc_prior ? acc_code_q : {row_idx_q, w_row_hit[1:0]};

    always_comb begin
        presc_d     = presc_q + PW'(1);
        row_idx_d   = row_idx_q;
        row_d       = row_q;
        acc_valid_d = acc_valid_q;
        acc_code_d  = acc_code_q;
        if (w_tick) begin
            presc_d     = '0;
            row_idx_d   = row_idx_q + 2'd1;
            row_d       = ~(4'b0001 << row_idx_d);
            acc_valid_d = w_scan_valid;
            acc_code_d  = w_scan_code;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk           (clk),
        .reset         (reset),
        .scan_done_i   (w_scan_done),
        .scan_valid_i  (w_scan_valid),
        .scan_code_i   (w_scan_code),
        .accept_o      (w_accept),
        .accept_code_o (w_accept_code),
        .held_o        (w_held)
    );

    assign w_read = cs && rd;

    // An accept coinciding with a read means the CPU consumed the old key.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        code_d    = code_q;
        if (w_accept) begin
            pending_d = 1'b1;
            overrun_d = w_read ? 1'b0 : (overrun_q || pending_q);
            code_d    = w_accept_code;
        end else if (w_read) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_comb begin
        data_d                = '0;
        data_d[PEND_BIT]      = pending_q;
        data_d[OVR_BIT]       = overrun_q;
        data_d[HELD_BIT]      = w_held;
        data_d[KEY_W-1:0]     = code_q;
    end

    assign o_row     = row_q;
    assign o_data    = data_q;
    assign o_key_irq = data_q[PEND_BIT];

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan
// Description : Directed self-checking bench for keypad_scan with a keypad model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        rd;
    logic [3:0]  i_col;
    logic [3:0]  o_row;
    logic [31:0] o_data;
    logic        o_key_irq;
    logic [15:0] keys;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] keys;
        bit          cs;
        bit          rd;
        int          cycles;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .rd        (rd),
        .i_col     (i_col),
        .o_row     (o_row),
        .o_data    (o_data),
        .o_key_irq (o_key_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        i_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!o_row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) i_col[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] k, input bit c, input bit r, input int n,
                       input logic [31:0] e, input string nm);
        vec_t v;
        v.keys = k; v.cs = c; v.rd = r; v.cycles = n; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic wait_row3_entry();
        int n;
        n = 0;
        while (o_row == 4'b0111 && n < 40) begin @(negedge clk); n++; end
        while (o_row != 4'b0111 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL row3_wait: got timeout expected o_row 0111");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        keys     = 16'h0000;
        cs       = 1'b0;
        rd       = 1'b0;
        reset    = 1'b1;

        // Main table: {keys, cs, rd, wait, expected o_data after the wait}
        add(16'h0000, 0, 0, 16, 32'h0000_0000, "idle");
        add(16'h0200, 0, 0, 64, 32'h8000_0019, "press9");
        add(16'h0200, 1, 0,  4, 32'h8000_0019, "cs_only");
        add(16'h0200, 1, 1,  4, 32'h0000_0019, "read9");
        add(16'h0000, 0, 0, 64, 32'h0000_0009, "release9");
        add(16'h0020, 0, 0, 64, 32'h8000_0015, "press5");
        add(16'h0000, 0, 0, 64, 32'h8000_0005, "release5");
        add(16'h0040, 0, 0, 64, 32'hC000_0016, "overrun6");
        add(16'h0000, 0, 0, 64, 32'hC000_0006, "release6");
        add(16'h0000, 1, 1,  4, 32'h0000_0006, "read_ovr");
        add(16'h0108, 0, 0, 64, 32'h8000_0013, "multi_rows");
        add(16'h0000, 0, 0, 64, 32'h8000_0003, "release3");
        add(16'h0000, 1, 1,  4, 32'h0000_0003, "read3");
        add(16'h0050, 0, 0, 64, 32'h8000_0014, "multi_cols");
        add(16'h0000, 1, 1, 64, 32'h0000_0004, "read_rel4");
        add(16'h8000, 0, 0, 64, 32'h8000_001F, "press15");
        add(16'h0000, 1, 1, 64, 32'h0000_000F, "read_rel15");
        add(16'h8001, 0, 0, 64, 32'h8000_0010, "press0_15");
        add(16'h0000, 1, 1, 64, 32'h0000_0000, "read_rel0");
        add(16'h0080, 0, 0, 16, 32'h0000_0000, "bounce_on");
        add(16'h0000, 0, 0, 64, 32'h0000_0000, "bounce_off");
        add(16'h0020, 0, 0, 64, 32'h8000_0015, "press5b");
        add(16'h0000, 0, 0, 64, 32'h8000_0005, "release5b");
        add(16'h0040, 0, 0, 64, 32'hC000_0016, "overrun6b");
        add(16'h0000, 0, 0, 64, 32'hC000_0006, "release6b");

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_row", {28'd0, o_row}, 32'h0000_000E);
        check("rst_data", o_data, 32'h0000_0000);
        check("rst_irq", {31'd0, o_key_irq}, 32'd0);
        reset = 1'b0;

        // Row walk: one step every 4 cycles
        begin
            logic [3:0] rows [5];
            rows[0] = 4'b1110; rows[1] = 4'b1101; rows[2] = 4'b1011;
            rows[3] = 4'b0111; rows[4] = 4'b1110;
            repeat (3) @(negedge clk);
            for (int s = 0; s < 4; s++) begin
                check($sformatf("row_hold%0d", s), {28'd0, o_row}, {28'd0, rows[s]});
                @(negedge clk);
                check($sformatf("row_step%0d", s), {28'd0, o_row}, {28'd0, rows[s+1]});
                repeat (3) @(negedge clk);
            end
        end

        for (int i = 0; i < tbl.size(); i++) begin
            keys = tbl[i].keys;
            if (tbl[i].cs) begin
                cs = 1'b1;
                rd = tbl[i].rd;
                if (tbl[i].rd && i > 0)
                    check({tbl[i].name, "_pre"}, o_data, tbl[i-1].exp);
                @(negedge clk);
                cs = 1'b0;
                rd = 1'b0;
            end
            repeat (tbl[i].cycles) @(negedge clk);
            check(tbl[i].name, o_data, tbl[i].exp);
            check({tbl[i].name, "_irq"}, {31'd0, o_key_irq}, {31'd0, tbl[i].exp[31]});
        end

        // Read landing on the exact cycle key 10 is accepted
        wait_row3_entry();
        keys = 16'h0400;
        wait_row3_entry();
        wait_row3_entry();
        repeat (3) @(negedge clk);
        cs = 1'b1;
        rd = 1'b1;
        check("accept_read_pre", o_data, 32'hC000_0006);
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
        repeat (3) @(negedge clk);
        check("accept_read", o_data, 32'h8000_001A);
        check("accept_read_irq", {31'd0, o_key_irq}, 32'd1);
        keys = 16'h0000;
        repeat (64) @(negedge clk);

        // Reset in the middle of debouncing key 2
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        keys = 16'h0004;
        repeat (20) @(negedge clk);
        check("pre_rst_debounce", o_data, 32'h0000_0000);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_data", o_data, 32'h0000_0000);
        check("midrst_row", {28'd0, o_row}, 32'h0000_000E);
        reset = 1'b0;
        repeat (31) @(negedge clk);
        check("rst_restart_early", o_data, 32'h0000_0000);
        repeat (3) @(negedge clk);
        check("rst_restart_accept", o_data, 32'h8000_0012);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- 4x4 matrix keypad reader; the input-side counterpart of the multiplexed seven-segment display driver.
- Drives one keypad row low at a time, samples the column lines, and debounces over whole scans.
- Latches a 4-bit key code into a CPU-readable status word.
- Sits on the same memory-mapped peripheral bus as the display (cs strobe, 32-bit data) and feeds game input (flap/start) to the CPU.

Parameters:
- SCAN_DIV, 32768: clk cycles per row step (scan tick period); legal range 4..65536.
- DEBOUNCE_SCANS, 4: consecutive full scans needed to accept a press and to accept a release; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cs  input  1  peripheral select for this block
- rd  input  1  read strobe; a read occurs on a cycle where cs && rd
- i_col  input  4  keypad columns, active-low (pulled up), asynchronous to clk
- o_row  output  4  row drive, active-low, exactly one bit low
- o_data  output  32  status word (registered)
- o_key_irq  output  1  equals the pending bit (o_data[31])

Behaviour:
- Reset (synchronous, active-high):
  - prescaler 0; row_idx 0; o_row 4'b1110.
  - col sync flops 4'hF; FSM IDLE; debounce count 0.
  - pending 0; overrun 0; held 0; code 0; o_data 32'h0; o_key_irq 0.
  - Reset mid-debounce or mid-hold discards all progress.
- Input sync: i_col passes through 2 flops; only the synced value is used.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick = 1 on the cycle the count equals SCAN_DIV-1.
- Row scan, on each tick:
  - Sample the synced columns for the current row_idx.
  - Then row_idx <= row_idx+1 (wraps 3->0); o_row <= ~(1<<row_idx_next).
  - A row is held for SCAN_DIV cycles, so there is settle time >= sync latency.
- Scan result:
  - A key is pressed when column bit c is 0 while row r is driven; code = r*4+c.
  - Several keys pressed: the lowest code wins. Per row the lowest column is taken; the first row that has a hit is kept for the scan.
  - On the tick that samples row 3, the scan completes and scan_valid/scan_code is presented to the FSM. That is one scan per 4 ticks.
- Debounce FSM (advances only on scan completion):
  - IDLE: key k seen -> DEBOUNCE with cand=k, cnt=1. If DEBOUNCE_SCANS=1, go directly to accept. No key -> stay in IDLE.
  - DEBOUNCE:
    - Same k -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> accept and go to HELD.
    - Different key -> restart with cand=new, cnt=1.
    - No key -> IDLE.
  - Accept: code<=cand; held<=1; pending<=1; overrun<=overrun|pending (evaluated before the read clear below).
  - HELD:
    - Key changes are ignored.
    - Scans with no key increment the release count; any key seen resets it to 0.
    - When the release count reaches DEBOUNCE_SCANS -> held<=0 and go to IDLE.
- Register map (o_data):
  - [31] pending
  - [30] overrun
  - [29:5] 0
  - [4] held
  - [3:0] code
  - o_data is updated every cycle from the state registers (1-cycle latency from state change).
- Read (cs&&rd): pending<=0 and overrun<=0 on the next edge. o_data presented during the read cycle is the pre-clear value.
- Read and accept on the same cycle: the accept wins. pending=1, overrun=0 (the old key was consumed), code=new.
- cs without rd: no effect.
- code is never cleared except by reset; it keeps the last accepted key.

Decomposition:
- Shared package (periph_pkg):
  - KEY_W=4
  - status bit positions (PEND_BIT=31, OVR_BIT=30, HELD_BIT=4)
  - debounce FSM state enum {IDLE, DEBOUNCE, HELD}
- One natural sub-module: keypad_debounce.
  - Inputs: scan_done, scan_valid, scan_code.
  - Outputs: accept, accept_code, held.
  - Contains the FSM and counters.
- keypad_scan keeps the prescaler, row drive, sync, scan encoding and the status register.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2; one scan = 16 cycles):
- Reset for 2 cycles -> o_row=4'b1110, o_data=32'h0. Free-run -> o_row sequence 1110,1101,1011,0111,1110 with a change every 4 cycles.
- Hold row2/col1 (i_col[1] low while o_row[2]=0) for 3 scans -> o_data=32'h8000_0019, o_key_irq=1. Read -> next cycle o_data=32'h0000_0019. Release for 2 scans -> o_data=32'h0000_0009.
- Bounce: key 7 present for 1 scan then absent for 3 scans -> pending stays 0, o_data=32'h0.
- Simultaneous keys: row0/col3 and row2/col0 held for 3 scans -> code 3, o_data=32'h8000_0013.
- Overrun: accept key 5, release, accept key 6 with no read -> o_data=32'hC000_0016. Issue a read on the exact cycle of a third accept (key 10) -> o_data=32'h8000_001A.
- Reset asserted mid-DEBOUNCE (key 2 seen for 1 scan) -> next cycle o_data=32'h0 and o_row=4'b1110. Continue holding key 2 -> pending only after 2 full scans measured from reset release.
